// File: rtl/fragment_video_framer.sv
// Re-frames the flat rendered-fragment stream into AXI4-Stream video (tuser = SOF, tlast = EOL)
// through a small FIFO, flagging frames that are shorter or longer than the configured size.
module fragment_video_framer #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DIM_W      = 16,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic              aclk,
   input  logic              resetn,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic              frame_done,
   output logic              err_short,
   output logic              err_long,
   output logic              busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = DATA_W + 3;

   typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
   logic [DIM_W-1:0]  x_q, x_d, y_q, y_d;
   logic              err_short_q, err_short_d, err_long_q, err_long_d;
   logic              frame_done_q;

   logic [EW-1:0]     mem_q [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic              fifo_full, fifo_empty, push, pop;
   logic [EW-1:0]     push_entry, head;

   logic              last_x, last_y, at_final, sof, eol, eof;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign last_x   = (x_q == width_q - DIM_W'(1));
   assign last_y   = (y_q == height_q - DIM_W'(1));
   assign at_final = last_x && last_y;
   assign sof      = (x_q == '0) && (y_q == '0);
   // An early tlast closes the partial line as well as the frame.
   assign eol      = last_x || s_axis_tlast;
   assign eof      = at_final || s_axis_tlast;

   assign push_entry = {eof, sof, eol, s_axis_tdata};

   always_comb begin
      state_d       = state_q;
      width_d       = width_q;
      height_d      = height_q;
      x_d           = x_q;
      y_d           = y_q;
      err_short_d   = err_short_q;
      err_long_d    = err_long_q;
      s_axis_tready = 1'b0;
      push          = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_valid) begin
               if ((cfg_width != '0) && (cfg_height != '0)) begin
                  width_d     = cfg_width;
                  height_d    = cfg_height;
                  x_d         = '0;
                  y_d         = '0;
                  err_short_d = 1'b0;
                  err_long_d  = 1'b0;
                  state_d     = StStream;
               end else begin
                  err_short_d = 1'b1;
               end
            end
         end
         StStream: begin
            s_axis_tready = !fifo_full;
            if (s_axis_tvalid && !fifo_full) begin
               push = 1'b1;
               if (s_axis_tlast) begin
                  state_d = StIdle;
                  if (!at_final) err_short_d = 1'b1;
               end else if (at_final) begin
                  err_long_d = 1'b1;
                  state_d    = StDrain;
               end else if (last_x) begin
                  x_d = '0;
                  y_d = y_q + DIM_W'(1);
               end else begin
                  x_d = x_q + DIM_W'(1);
               end
            end
         end
         StDrain: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         width_q     <= '0;
         height_q    <= '0;
         x_q         <= '0;
         y_q         <= '0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         x_q         <= x_d;
         y_q         <= y_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
      end
   end

   assign head = mem_q[rd_ptr_q[AW-1:0]];
   assign pop  = !fifo_empty && m_axis_tready;

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         frame_done_q <= pop && head[DATA_W+2];
      end
   end

   // Storage needs no reset: nothing is visible until the pointers say so.
   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
   end

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_empty ? '0 : head[DATA_W-1:0];
   assign m_axis_tlast  = !fifo_empty && head[DATA_W];
   assign m_axis_tuser  = !fifo_empty && head[DATA_W+1];
   assign frame_done    = frame_done_q;
   assign err_short     = err_short_q;
   assign err_long      = err_long_q;
   assign cfg_ready     = (state_q == StIdle);
   assign busy          = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_fragment_video_framer.sv
// Directed bench for fragment_video_framer: normal, backpressured, short, long, zero-size and
// reset-interrupted frames, with output pixels logged and compared against hand-derived values.
module tb_fragment_video_framer;

   logic        aclk = 1'b0;
   logic        resetn;
   logic [15:0] cfg_width, cfg_height;
   logic        cfg_valid, cfg_ready;
   logic [31:0] s_tdata;
   logic        s_tvalid, s_tready, s_tlast;
   logic [31:0] m_tdata;
   logic        m_tvalid, m_tready, m_tlast, m_tuser;
   logic        frame_done, err_short, err_long, busy;

   int checks   = 0;
   int failures = 0;
   int rdy_mode = 1;  // 0: stalled, 1: always ready, 2: ready one cycle in three
   int cyc      = 0;
   int stall_err = 0;
   logic [63:0] rx[$];
   int          fd[$];

   fragment_video_framer #(
      .DATA_W     (32),
      .DIM_W      (16),
      .FIFO_DEPTH (4)
   ) dut (
      .aclk          (aclk),
      .resetn        (resetn),
      .cfg_width     (cfg_width),
      .cfg_height    (cfg_height),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
      .frame_done    (frame_done),
      .err_short     (err_short),
      .err_long      (err_long),
      .busy          (busy)
   );

   always #5 aclk = ~aclk;

   function automatic logic [63:0] px(input logic user, input logic last, input logic [31:0] d);
      return {30'b0, user, last, d};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Downstream ready pattern.
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge aclk);
         #1;
         cyc++;
         m_tready = (rdy_mode == 1) || ((rdy_mode == 2) && (cyc % 3 == 0));
      end
   end

   // Output monitor: logs handshaken pixels, frame_done positions and stall stability.
   initial begin
      logic        prev_stall;
      logic [63:0] prev_px, cur;
      prev_stall = 1'b0;
      prev_px    = '0;
      forever begin
         @(negedge aclk);
         cur = px(m_tuser, m_tlast, m_tdata);
         if (!resetn) begin
            prev_stall = 1'b0;
         end else begin
            if (frame_done) fd.push_back(rx.size());
            if (prev_stall && (!m_tvalid || cur != prev_px)) stall_err++;
            prev_stall = m_tvalid && !m_tready;
            prev_px    = cur;
            if (m_tvalid && m_tready) rx.push_back(cur);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_logs();
      rx.delete();
      fd.delete();
   endtask

   task automatic cfg(input int w, input int h);
      @(posedge aclk);
      #1;
      cfg_width  = 16'(w);
      cfg_height = 16'(h);
      cfg_valid  = 1'b1;
      @(posedge aclk);
      #1;
      cfg_valid  = 1'b0;
   endtask

   task automatic send(input int n, input int last_at, input logic [31:0] base, input int limit,
                       output int sent);
      int waited;
      bit ok;
      sent = 0;
      @(posedge aclk);
      #1;
      for (int i = 0; i < n; i++) begin
         s_tdata  = base + 32'(i);
         s_tlast  = (i == last_at);
         s_tvalid = 1'b1;
         waited   = 0;
         ok       = 1'b0;
         while (!ok && waited < limit) begin
            @(negedge aclk);
            if (s_tready) ok = 1'b1;
            else waited++;
         end
         if (!ok) break;
         sent++;
         @(posedge aclk);
         #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int waited;
      waited = 0;
      @(negedge aclk);
      while (busy && waited < limit) begin
         @(negedge aclk);
         waited++;
      end
      check_eq("idle_timeout", 64'(busy), 64'(0));
      repeat (2) @(negedge aclk);
   endtask

   task automatic check_frame(input int w, input int npix, input logic [31:0] base);
      check_eq("rx_count", 64'(rx.size()), 64'(npix));
      for (int i = 0; i < npix && i < rx.size(); i++)
         check_eq($sformatf("pixel%0d", i), rx[i],
                  px(i == 0, (i % w == w - 1) || (i == npix - 1), base + 32'(i)));
      check_eq("fd_count", 64'(fd.size()), 64'(1));
      if (fd.size() > 0) check_eq("fd_pos", 64'(fd[0]), 64'(npix));
   endtask

   initial begin
      int sent;
      resetn     = 1'b0;
      cfg_width  = '0;
      cfg_height = '0;
      cfg_valid  = 1'b0;
      s_tdata    = '0;
      s_tvalid   = 1'b0;
      s_tlast    = 1'b0;
      repeat (3) @(negedge aclk);
      check_eq("rst_cfg_ready", 64'(cfg_ready), 64'(1));
      check_eq("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check_eq("rst_s_tready", 64'(s_tready), 64'(0));
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_errs", 64'({err_short, err_long, frame_done}), 64'(0));
      @(posedge aclk);
      #1;
      resetn = 1'b1;

      // Normal 4x2 frame.
      clear_logs();
      cfg(4, 2);
      send(8, 7, 32'h100, 200, sent);
      check_eq("n_sent", 64'(sent), 64'(8));
      wait_idle(200);
      check_frame(4, 8, 32'h100);
      check_eq("n_err_short", 64'(err_short), 64'(0));
      check_eq("n_err_long", 64'(err_long), 64'(0));

      // Backpressure 4x4: fill with the sink stalled, then ready one cycle in three.
      clear_logs();
      rdy_mode = 0;
      cfg(4, 4);
      send(16, 15, 32'h200, 10, sent);
      check_eq("bp_fill", 64'(sent), 64'(4));
      check_eq("bp_s_tready", 64'(s_tready), 64'(0));
      rdy_mode = 2;
      send(12, 11, 32'h204, 300, sent);
      check_eq("bp_rest", 64'(sent), 64'(12));
      wait_idle(400);
      check_frame(4, 16, 32'h200);
      check_eq("bp_stall_stable", 64'(stall_err), 64'(0));
      rdy_mode = 1;

      // Short 4x2 frame: tlast on fragment 5.
      clear_logs();
      cfg(4, 2);
      send(6, 5, 32'h300, 200, sent);
      wait_idle(200);
      check_frame(4, 6, 32'h300);
      check_eq("s_err_short", 64'(err_short), 64'(1));
      check_eq("s_err_long", 64'(err_long), 64'(0));
      check_eq("s_cfg_ready", 64'(cfg_ready), 64'(1));

      // Long 2x2 frame: 7 fragments, extras dropped.
      clear_logs();
      cfg(2, 2);
      send(7, 6, 32'h400, 200, sent);
      check_eq("l_sent", 64'(sent), 64'(7));
      wait_idle(200);
      check_frame(2, 4, 32'h400);
      check_eq("l_err_long", 64'(err_long), 64'(1));
      check_eq("l_err_short", 64'(err_short), 64'(0));
      check_eq("l_cfg_ready", 64'(cfg_ready), 64'(1));

      // Zero dimension is rejected, then a valid 2x1 frame.
      clear_logs();
      cfg(0, 5);
      @(negedge aclk);
      check_eq("z_err_short", 64'(err_short), 64'(1));
      check_eq("z_cfg_ready", 64'(cfg_ready), 64'(1));
      check_eq("z_s_tready", 64'(s_tready), 64'(0));
      cfg(2, 1);
      @(negedge aclk);
      check_eq("z_err_clear", 64'(err_short), 64'(0));
      send(2, 1, 32'h500, 200, sent);
      wait_idle(200);
      check_frame(2, 2, 32'h500);

      // Reset mid-frame with the sink stalled.
      clear_logs();
      rdy_mode = 0;
      cfg(4, 2);
      send(3, 99, 32'h600, 50, sent);
      check_eq("r_sent", 64'(sent), 64'(3));
      @(posedge aclk);
      #1;
      resetn = 1'b0;
      @(negedge aclk);
      check_eq("r_m_tvalid", 64'(m_tvalid), 64'(0));
      check_eq("r_busy", 64'(busy), 64'(0));
      check_eq("r_cfg_ready", 64'(cfg_ready), 64'(1));
      check_eq("r_frame_done", 64'(frame_done), 64'(0));
      @(posedge aclk);
      #1;
      resetn = 1'b1;
      rdy_mode = 1;
      clear_logs();
      cfg(4, 2);
      send(8, 7, 32'h700, 200, sent);
      wait_idle(200);
      check_frame(4, 8, 32'h700);
      check_eq("r_errs", 64'({err_short, err_long}), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
